inst_decoder: RTL and testbench



---
 rtl/inst_decoder_pkg.sv | 78 +++++++
 rtl/inst_decoder_ctrl.sv | 39 +++
 rtl/inst_decoder.sv | 95 +++++++++
 tb/tb_inst_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_decoder_pkg.sv
// Shared definitions for the decode stage of the 16-bit, 4-register core.
// Contents: opcode encodings, ALU operation codes, instruction field bit
// positions, the datapath control bundle type and a helper that builds one.
// Used by inst_decoder_ctrl and inst_decoder.
package inst_decoder_pkg;

  // Opcode encodings (instr[15:12])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_ANDI = 4'h9;
  localparam logic [3:0] OP_ORI  = 4'hA;
  localparam logic [3:0] OP_SLLI = 4'hB;
  localparam logic [3:0] OP_LW   = 4'hC;
  localparam logic [3:0] OP_SW   = 4'hD;
  localparam logic [3:0] OP_LI   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation codes; code 7 is reserved and never produced
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;

  // Instruction field positions; rd and imm deliberately overlap in [7:6]
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned RS_LSB     = 10;
  localparam int unsigned RT_LSB     = 8;
  localparam int unsigned RD_LSB     = 6;
  localparam int unsigned REG_W      = 2;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned IMM_W      = 8;

  // Datapath control bundle
  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src1;
    logic       alu_src2;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = 9'h000;

  function automatic ctrl_t make_ctrl(
    input logic       reg_dst,
    input logic       reg_write,
    input logic       alu_src1,
    input logic       alu_src2,
    input logic [2:0] alu_op,
    input logic       mem_write,
    input logic       mem_to_reg
  );
    ctrl_t c;
    c.reg_dst    = reg_dst;
    c.reg_write  = reg_write;
    c.alu_src1   = alu_src1;
    c.alu_src2   = alu_src2;
    c.alu_op     = alu_op;
    c.mem_write  = mem_write;
    c.mem_to_reg = mem_to_reg;
    return c;
  endfunction

endpackage

// File: rtl/inst_decoder_ctrl.sv
// Combinational opcode -> datapath control lookup.
// Ports:
//   opcode  in   4  instruction opcode
//   ctrl    out  9  control bundle (ctrl_t)
// HALT decodes to the all-zero bundle; the halt flag itself is produced in
// the top level when INST_DECODER_HALT_EN is defined.
module inst_decoder_ctrl
  import inst_decoder_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  // Control table lookup
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_NOP:  ctrl = CTRL_NOP;
      OP_ADD:  ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0);
      OP_SUB:  ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALU_SUB, 1'b0, 1'b0);
      OP_AND:  ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b0);
      OP_OR:   ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALU_OR,  1'b0, 1'b0);
      OP_XOR:  ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALU_XOR, 1'b0, 1'b0);
      OP_SLT:  ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALU_SLT, 1'b0, 1'b0);
      OP_SLL:  ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALU_SLL, 1'b0, 1'b0);
      OP_ADDI: ctrl = make_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0);
      OP_ANDI: ctrl = make_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALU_AND, 1'b0, 1'b0);
      OP_ORI:  ctrl = make_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALU_OR,  1'b0, 1'b0);
      OP_SLLI: ctrl = make_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALU_SLL, 1'b0, 1'b0);
      OP_LW:   ctrl = make_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1);
      OP_SW:   ctrl = make_ctrl(1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0);
      // LI: ALU A forced to 0 so the result is 0 + imm
      OP_LI:   ctrl = make_ctrl(1'b0, 1'b1, 1'b1, 1'b1, ALU_ADD, 1'b0, 1'b0);
      OP_HALT: ctrl = CTRL_NOP;
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/inst_decoder.sv
// Decode stage: slices the fetched instruction into register addresses and
// immediate, looks up datapath control, and registers everything (latency 1).
// Per-edge priority: flush (load NOP/all-0) > stall (hold) > decode.
// Optional feature macro: INST_DECODER_HALT_EN adds a registered halt output
// that is 1 after an opcode 0xF decode.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   instruction  in   16    fetched instruction
//   stall        in   1     hold all outputs
//   flush        in   1     load bubble (all outputs 0)
//   opcode/rs_addr/rt_addr/rd_addr/immediate   registered raw field slices
//   RegDst/RegWrite/ALUSrc1/ALUSrc2/ALUOp/MemWrite/MemToReg  registered controls
//   halt         out  1     (INST_DECODER_HALT_EN only)
module inst_decoder
  import inst_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruction,
  input  logic        stall,
  input  logic        flush,
  output logic [3:0]  opcode,
  output logic [1:0]  rs_addr,
  output logic [1:0]  rt_addr,
  output logic [1:0]  rd_addr,
  output logic [7:0]  immediate,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [2:0]  ALUOp,
  output logic        MemWrite,
  output logic        MemToReg
`ifdef INST_DECODER_HALT_EN
  ,
  output logic        halt
`endif
);

  ctrl_t                ctrl_s;
  ctrl_t                ctrl_r;
  // Fields are pure slices, so holding the whole instruction is enough
  logic [INSTR_W-1:0]   instr_r;

  inst_decoder_ctrl u_ctrl (
    .opcode (instruction[OPCODE_LSB +: OPCODE_W]),
    .ctrl   (ctrl_s)
  );

  // Decode pipeline register with flush/stall priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= 16'h0000;
      ctrl_r  <= CTRL_NOP;
    end else if (flush) begin
      instr_r <= 16'h0000;
      ctrl_r  <= CTRL_NOP;
    end else if (!stall) begin
      instr_r <= instruction;
      ctrl_r  <= ctrl_s;
    end
  end

`ifdef INST_DECODER_HALT_EN
  logic halt_r;

  // Halt flag register, same flush/stall priority as the decode register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_r <= 1'b0;
    end else if (flush) begin
      halt_r <= 1'b0;
    end else if (!stall) begin
      halt_r <= (instruction[OPCODE_LSB +: OPCODE_W] == OP_HALT);
    end
  end

  assign halt = halt_r;
`endif

  assign opcode    = instr_r[OPCODE_LSB +: OPCODE_W];
  assign rs_addr   = instr_r[RS_LSB +: REG_W];
  assign rt_addr   = instr_r[RT_LSB +: REG_W];
  assign rd_addr   = instr_r[RD_LSB +: REG_W];
  assign immediate = instr_r[IMM_LSB +: IMM_W];

  assign RegDst    = ctrl_r.reg_dst;
  assign RegWrite  = ctrl_r.reg_write;
  assign ALUSrc1   = ctrl_r.alu_src1;
  assign ALUSrc2   = ctrl_r.alu_src2;
  assign ALUOp     = ctrl_r.alu_op;
  assign MemWrite  = ctrl_r.mem_write;
  assign MemToReg  = ctrl_r.mem_to_reg;

endmodule

// File: tb/tb_inst_decoder.sv
// Self-checking bench for inst_decoder: directed cases plus randomized
// instruction/stall/flush traffic against a table-driven reference model.
module tb_inst_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instruction;
  logic        stall;
  logic        flush;
  logic [3:0]  opcode;
  logic [1:0]  rs_addr, rt_addr, rd_addr;
  logic [7:0]  immediate;
  logic        RegDst, RegWrite, ALUSrc1, ALUSrc2, MemWrite, MemToReg;
  logic [2:0]  ALUOp;
`ifdef INST_DECODER_HALT_EN
  logic        halt;
  logic        exp_halt = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Reference control table, one row per opcode:
  // {RegDst, RegWrite, ALUSrc1, ALUSrc2, ALUOp[2:0], MemWrite, MemToReg}
  logic [8:0]  ref_tbl [16];
  logic [26:0] exp_r = 27'h0;
  logic [26:0] got_s;
  logic [26:0] saved;

  inst_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .stall       (stall),
    .flush       (flush),
    .opcode      (opcode),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rd_addr     (rd_addr),
    .immediate   (immediate),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrc1     (ALUSrc1),
    .ALUSrc2     (ALUSrc2),
    .ALUOp       (ALUOp),
    .MemWrite    (MemWrite),
    .MemToReg    (MemToReg)
`ifdef INST_DECODER_HALT_EN
    ,
    .halt        (halt)
`endif
  );

  always #5 clk = ~clk;

  assign got_s = {opcode, rs_addr, rt_addr, rd_addr, immediate,
                  RegDst, RegWrite, ALUSrc1, ALUSrc2, ALUOp, MemWrite, MemToReg};

  function automatic logic [26:0] model_decode(input logic [15:0] i);
    return {i[15:12], i[11:10], i[9:8], i[7:6], i[7:0], ref_tbl[i[15:12]]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare after
  task automatic cycle(input logic [15:0] ins, input logic st, input logic fl);
    instruction = ins;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    if (fl) begin
      exp_r = 27'h0;
`ifdef INST_DECODER_HALT_EN
      exp_halt = 1'b0;
`endif
    end else if (!st) begin
      exp_r = model_decode(ins);
`ifdef INST_DECODER_HALT_EN
      exp_halt = (ins[15:12] == 4'hF);
`endif
    end
    #1;
    check("bundle", {5'd0, got_s}, {5'd0, exp_r});
    check("no_wr_conflict", {31'd0, RegWrite & MemWrite}, 32'd0);
    check("aluop_not7", {31'd0, ALUOp == 3'd7}, 32'd0);
`ifdef INST_DECODER_HALT_EN
    check("halt", {31'd0, halt}, {31'd0, exp_halt});
`endif
  endtask

  initial begin
    ref_tbl[0]  = 9'b0_0_0_0_000_0_0;  // NOP
    ref_tbl[1]  = 9'b1_1_0_0_000_0_0;  // ADD
    ref_tbl[2]  = 9'b1_1_0_0_001_0_0;  // SUB
    ref_tbl[3]  = 9'b1_1_0_0_010_0_0;  // AND
    ref_tbl[4]  = 9'b1_1_0_0_011_0_0;  // OR
    ref_tbl[5]  = 9'b1_1_0_0_100_0_0;  // XOR
    ref_tbl[6]  = 9'b1_1_0_0_101_0_0;  // SLT
    ref_tbl[7]  = 9'b1_1_0_0_110_0_0;  // SLL
    ref_tbl[8]  = 9'b0_1_0_1_000_0_0;  // ADDI
    ref_tbl[9]  = 9'b0_1_0_1_010_0_0;  // ANDI
    ref_tbl[10] = 9'b0_1_0_1_011_0_0;  // ORI
    ref_tbl[11] = 9'b0_1_0_1_110_0_0;  // SLLI
    ref_tbl[12] = 9'b0_1_0_1_000_0_1;  // LW
    ref_tbl[13] = 9'b0_0_0_1_000_1_0;  // SW
    ref_tbl[14] = 9'b0_1_1_1_000_0_0;  // LI
    ref_tbl[15] = 9'b0_0_0_0_000_0_0;  // HALT

    // Reset with all-ones instruction present
    rst_n       = 1'b0;
    instruction = 16'hFFFF;
    stall       = 1'b0;
    flush       = 1'b0;
    #12;
    check("reset_outputs", {5'd0, got_s}, 32'd0);
`ifdef INST_DECODER_HALT_EN
    check("reset_halt", {31'd0, halt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    cycle(16'hFFFF, 1'b0, 1'b0);
    check("rel_opcode", {28'd0, opcode}, 32'hF);
    check("rel_rs", {30'd0, rs_addr}, 32'd3);
    check("rel_rt", {30'd0, rt_addr}, 32'd3);
    check("rel_rd", {30'd0, rd_addr}, 32'd3);
    check("rel_imm", {24'd0, immediate}, 32'd255);

    // Opcode sweep with zero operands
    for (int op = 0; op < 16; op++) begin
      logic [3:0] op4;
      op4 = op[3:0];
      cycle({op4, 12'h000}, 1'b0, 1'b0);
      check("sweep_opcode", {28'd0, opcode}, {28'd0, op4});
    end
`ifndef INST_DECODER_HALT_EN
    check("halt_as_nop", {23'd0, RegDst, RegWrite, ALUSrc1, ALUSrc2, ALUOp, MemWrite, MemToReg}, 32'd0);
`endif

    // ADD rd1, rs2, rt3
    cycle(16'h1B40, 1'b0, 1'b0);
    check("add_rs", {30'd0, rs_addr}, 32'd2);
    check("add_rt", {30'd0, rt_addr}, 32'd3);
    check("add_rd", {30'd0, rd_addr}, 32'd1);
    check("add_regdst", {31'd0, RegDst}, 32'd1);
    check("add_regwrite", {31'd0, RegWrite}, 32'd1);
    check("add_aluop", {29'd0, ALUOp}, 32'd0);

    // LW
    cycle(16'hC5A7, 1'b0, 1'b0);
    check("lw_rs", {30'd0, rs_addr}, 32'd1);
    check("lw_rt", {30'd0, rt_addr}, 32'd1);
    check("lw_imm", {24'd0, immediate}, 32'hA7);
    check("lw_alusrc2", {31'd0, ALUSrc2}, 32'd1);
    check("lw_memtoreg", {31'd0, MemToReg}, 32'd1);
    check("lw_regwrite", {31'd0, RegWrite}, 32'd1);

    // SW
    cycle(16'hD2FF, 1'b0, 1'b0);
    check("sw_memwrite", {31'd0, MemWrite}, 32'd1);
    check("sw_regwrite", {31'd0, RegWrite}, 32'd0);
    check("sw_alusrc2", {31'd0, ALUSrc2}, 32'd1);
    check("sw_imm", {24'd0, immediate}, 32'd255);

    // Stall for two cycles while the instruction changes
    saved = got_s;
    cycle(16'h2E15, 1'b1, 1'b0);
    check("stall1_frozen", {5'd0, got_s}, {5'd0, model_decode(16'hD2FF)});
    cycle(16'hE0C3, 1'b1, 1'b0);
    check("stall2_frozen", {5'd0, got_s}, {5'd0, model_decode(16'hD2FF)});
    // Flush beats stall
    cycle(16'h7FFF, 1'b1, 1'b1);
    check("flush_over_stall", {5'd0, got_s}, 32'd0);

`ifdef INST_DECODER_HALT_EN
    cycle(16'hF000, 1'b0, 1'b0);
    check("halt_set", {31'd0, halt}, 32'd1);
`else
    cycle(16'hF000, 1'b0, 1'b0);
    check("halt_ctrl_zero", {23'd0, RegDst, RegWrite, ALUSrc1, ALUSrc2, ALUOp, MemWrite, MemToReg}, 32'd0);
`endif

    // Asynchronous reset assertion mid-cycle
    cycle(16'h1FFF, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {5'd0, got_s}, 32'd0);
    exp_r = 27'h0;
`ifdef INST_DECODER_HALT_EN
    exp_halt = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ri;
      logic        rs, rf;
      ri = 16'($urandom);
      rs = ($urandom_range(0, 3) == 0);
      rf = ($urandom_range(0, 7) == 0);
      cycle(ri, rs, rf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
